// File: rtl/fb_ctrl_pkg.sv
// Shared types for the framebuffer access controller.
package fb_ctrl_pkg;

  typedef enum logic [1:0] {
    FILL_IDLE,
    FILL_RUN,
    FILL_DONE
  } fill_state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_VID,
    OWN_CPU
  } rd_owner_t;

endpackage

// File: rtl/fb_ctrl_if.sv
// Framebuffer RAM port bundle: one write port plus one registered read port.
interface fb_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
);

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr_w;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_addr_r;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport master (
    output ram_we,
    output ram_addr_w,
    output ram_din,
    output ram_addr_r,
    input  ram_dout
  );

  modport slave (
    input  ram_we,
    input  ram_addr_w,
    input  ram_din,
    input  ram_addr_r,
    output ram_dout
  );

endinterface

// File: rtl/fb_fill_engine.sv
// Clear-screen engine: writes one latched value to every framebuffer word,
// yielding the write port to the CPU whenever stall is high.
module fb_fill_engine
  import fb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_data,
  input  logic                  stall,
  output logic                  fill_we,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [DATA_WIDTH-1:0] fill_wdata,
  output logic                  fill_busy,
  output logic                  fill_done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = '1;

  fill_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    fill_we   = 1'b0;
    fill_busy = 1'b0;
    fill_done = 1'b0;
    unique case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          state_d = FILL_RUN;
          addr_d  = '0;
          data_d  = fill_data;
        end
      end
      FILL_RUN: begin
        fill_busy = 1'b1;
        fill_we   = !stall;
        // Address only advances on cycles that actually wrote; last word ends the run.
        if (!stall) begin
          if (addr_q == LastAddr) state_d = FILL_DONE;
          else                    addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      FILL_DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
        state_d   = FILL_IDLE;
      end
      default: state_d = FILL_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FILL_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign fill_addr  = addr_q;
  assign fill_wdata = data_q;

endmodule

// File: rtl/fb_ctrl.sv
// Framebuffer access controller: CPU-over-fill write arbitration, video-over-CPU
// read arbitration, and steering of the RAM's registered read data.
module fb_ctrl
  import fb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_wr_req,
  input  logic [ADDR_WIDTH-1:0] cpu_wr_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  output logic                  cpu_wr_ack,
  input  logic                  fill_start,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  fill_busy,
  output logic                  fill_done,
  input  logic                  vid_rd_en,
  input  logic [ADDR_WIDTH-1:0] vid_rd_addr,
  output logic [DATA_WIDTH-1:0] vid_rd_data,
  output logic                  vid_rd_valid,
  input  logic                  cpu_rd_req,
  input  logic [ADDR_WIDTH-1:0] cpu_rd_addr,
  output logic                  cpu_rd_ack,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_rd_valid,
  fb_ctrl_if.master             ram
);

  logic                  fill_we;
  logic [ADDR_WIDTH-1:0] fill_addr;
  logic [DATA_WIDTH-1:0] fill_wdata;
  logic                  vid_go;
  rd_owner_t             owner_q, owner_d;
  logic [ADDR_WIDTH-1:0] addr_r_q;

  fb_fill_engine #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_fill (
    .clk        (clk),
    .reset_n    (reset_n),
    .fill_start (fill_start),
    .fill_data  (fill_data),
    .stall      (cpu_wr_req),
    .fill_we    (fill_we),
    .fill_addr  (fill_addr),
    .fill_wdata (fill_wdata),
    .fill_busy  (fill_busy),
    .fill_done  (fill_done)
  );

  always_comb begin
    cpu_wr_ack     = reset_n & cpu_wr_req;
    ram.ram_we     = reset_n & (cpu_wr_req | fill_we);
    ram.ram_addr_w = cpu_wr_req ? cpu_wr_addr : fill_addr;
    ram.ram_din    = cpu_wr_req ? cpu_wr_data : fill_wdata;
  end

  // With no reader the last address is re-presented; the resulting read is ignored.
  always_comb begin
    vid_go         = reset_n & vid_rd_en;
    cpu_rd_ack     = reset_n & cpu_rd_req & ~vid_rd_en;
    ram.ram_addr_r = addr_r_q;
    owner_d        = OWN_NONE;
    if (vid_go) begin
      ram.ram_addr_r = vid_rd_addr;
      owner_d        = OWN_VID;
    end else if (cpu_rd_ack) begin
      ram.ram_addr_r = cpu_rd_addr;
      owner_d        = OWN_CPU;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q  <= OWN_NONE;
      addr_r_q <= '0;
    end else begin
      owner_q  <= owner_d;
      addr_r_q <= ram.ram_addr_r;
    end
  end

  assign vid_rd_valid = (owner_q == OWN_VID);
  assign cpu_rd_valid = (owner_q == OWN_CPU);
  assign vid_rd_data  = ram.ram_dout;
  assign cpu_rd_data  = ram.ram_dout;

endmodule
